pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 44 ++++
 rtl/pipeline_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Hazard inputs and stall/flush controls shared between the
//               pipeline datapath (master) and the pipeline controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if;
    // Hazard and event indications from the datapath
    logic load_use_hazard;
    logic muldiv_start;
    logic dmem_req;
    logic dmem_data_ok;
    logic exc_valid;
    // Pipeline controls back to the datapath
    logic PC_Stall;
    logic IF_ID_Stall;
    logic ID_EX_Stall;
    logic EX_MEM_Stall;
    logic MEM_WB_Stall;
    logic IF_ID_Flush;
    logic ID_EX_Flush;
    logic EX_MEM_Flush;
    logic MEM_WB_Flush;
    logic exc_redirect;
    logic muldiv_done;

    modport master (
        output load_use_hazard, muldiv_start, dmem_req, dmem_data_ok, exc_valid,
        input  PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall,
        input  IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush,
        input  exc_redirect, muldiv_done
    );

    modport slave (
        input  load_use_hazard, muldiv_start, dmem_req, dmem_data_ok, exc_valid,
        output PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall,
        output IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush,
        output exc_redirect, muldiv_done
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline stall/flush controller. Handles exceptions, data
//               memory wait states, multi-cycle mul/div stalls and load-use
//               bubbles. Optional macro PIPE_STALL_CNT_EN adds a saturating
//               32-bit stall_cycles counter of cycles with PC_Stall=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
    parameter int MULDIV_LAT = 32       // mul/div stall length, 1..63
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
`ifdef PIPE_STALL_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    pipeline_ctrl_if.slave   bus
);

    localparam logic [5:0] c_CNT_LOAD = 6'(MULDIV_LAT - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_MULDIV   = 2'd2
    } state_t;

    state_t     r_state;
    logic [5:0] r_cnt;

    // A data access is outstanding when requested but not yet completed
    logic w_mem_pending;
    assign w_mem_pending = bus.dmem_req && !bus.dmem_data_ok;

    // State and mul/div countdown; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.exc_valid) begin
                        r_state <= S_RUN;
                    end else if (w_mem_pending) begin
                        r_state <= S_MEM_WAIT;
                    end else if (bus.muldiv_start) begin
                        r_state <= S_MULDIV;
                        r_cnt   <= c_CNT_LOAD;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.dmem_data_ok) begin
                        r_state <= S_RUN;
                    end
                end
                S_MULDIV: begin
                    if (bus.exc_valid) begin
                        r_state <= S_RUN;
                        r_cnt   <= 6'd0;
                    end else if (r_cnt != 6'd0) begin
                        r_cnt   <= r_cnt - 6'd1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= 6'd0;
                end
            endcase
        end
    end

    // Stall/flush decode; everything forced low while reset is held
    always_comb begin
        bus.PC_Stall     = 1'b0;
        bus.IF_ID_Stall  = 1'b0;
        bus.ID_EX_Stall  = 1'b0;
        bus.EX_MEM_Stall = 1'b0;
        bus.MEM_WB_Stall = 1'b0;
        bus.IF_ID_Flush  = 1'b0;
        bus.ID_EX_Flush  = 1'b0;
        bus.EX_MEM_Flush = 1'b0;
        bus.MEM_WB_Flush = 1'b0;
        bus.exc_redirect = 1'b0;
        bus.muldiv_done  = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_RUN: begin
                    if (bus.exc_valid) begin
                        bus.IF_ID_Flush  = 1'b1;
                        bus.ID_EX_Flush  = 1'b1;
                        bus.EX_MEM_Flush = 1'b1;
                        bus.MEM_WB_Flush = 1'b1;
                        bus.exc_redirect = 1'b1;
                    end else if (w_mem_pending) begin
                        bus.PC_Stall     = 1'b1;
                        bus.IF_ID_Stall  = 1'b1;
                        bus.ID_EX_Stall  = 1'b1;
                        bus.EX_MEM_Stall = 1'b1;
                        bus.MEM_WB_Flush = 1'b1;
                    end else if (bus.muldiv_start) begin
                        bus.PC_Stall     = 1'b1;
                        bus.IF_ID_Stall  = 1'b1;
                        bus.ID_EX_Stall  = 1'b1;
                        bus.EX_MEM_Flush = 1'b1;
                    end else if (bus.load_use_hazard) begin
                        bus.PC_Stall     = 1'b1;
                        bus.IF_ID_Stall  = 1'b1;
                        bus.ID_EX_Flush  = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (!bus.dmem_data_ok) begin
                        bus.PC_Stall     = 1'b1;
                        bus.IF_ID_Stall  = 1'b1;
                        bus.ID_EX_Stall  = 1'b1;
                        bus.EX_MEM_Stall = 1'b1;
                        bus.MEM_WB_Flush = 1'b1;
                    end
                end
                S_MULDIV: begin
                    if (bus.exc_valid) begin
                        bus.IF_ID_Flush  = 1'b1;
                        bus.ID_EX_Flush  = 1'b1;
                        bus.EX_MEM_Flush = 1'b1;
                        bus.MEM_WB_Flush = 1'b1;
                        bus.exc_redirect = 1'b1;
                    end else if (r_cnt != 6'd0) begin
                        bus.PC_Stall     = 1'b1;
                        bus.IF_ID_Stall  = 1'b1;
                        bus.ID_EX_Stall  = 1'b1;
                        bus.EX_MEM_Flush = 1'b1;
                    end else begin
                        bus.muldiv_done  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
        end else if (bus.PC_Stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Scoreboard bench for pipeline_ctrl with MULDIV_LAT=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    // Output vector order:
    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB stalls, IF_ID, ID_EX, EX_MEM, MEM_WB
    //  flushes, exc_redirect, muldiv_done}
    localparam logic [10:0] c_Z    = 11'b00000_0000_0_0;
    localparam logic [10:0] c_EXC  = 11'b00000_1111_1_0;
    localparam logic [10:0] c_MEMW = 11'b11110_0001_0_0;
    localparam logic [10:0] c_MD   = 11'b11100_0010_0_0;
    localparam logic [10:0] c_DONE = 11'b00000_0000_0_1;
    localparam logic [10:0] c_LU   = 11'b11000_0100_0_0;

    // Input vector order: {load_use, muldiv_start, dmem_req, dmem_data_ok, exc}
    localparam logic [4:0] c_I0   = 5'b00000;
    localparam logic [4:0] c_IEXC = 5'b00001;
    localparam logic [4:0] c_ILU  = 5'b10000;
    localparam logic [4:0] c_IMD  = 5'b01000;
    localparam logic [4:0] c_IMEM = 5'b00100;

    typedef struct {
        logic [10:0] exp;
        string       name;
    } sb_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    sb_t  q[$];

    pipeline_ctrl_if bus ();

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] m_stalls;
`endif

    pipeline_ctrl #(.MULDIV_LAT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef PIPE_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [4:0] in,
                        input logic [10:0] exp, input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n                = rst;
        bus.load_use_hazard  = in[4];
        bus.muldiv_start     = in[3];
        bus.dmem_req         = in[2];
        bus.dmem_data_ok     = in[1];
        bus.exc_valid        = in[0];
        e.exp  = exp;
        e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: compares the presented controls against the queued expectation
    initial begin
        sb_t         e;
        logic [10:0] act;
`ifdef PIPE_STALL_CNT_EN
        m_stalls = 32'd0;
`endif
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.PC_Stall, bus.IF_ID_Stall, bus.ID_EX_Stall,
                       bus.EX_MEM_Stall, bus.MEM_WB_Stall, bus.IF_ID_Flush,
                       bus.ID_EX_Flush, bus.EX_MEM_Flush, bus.MEM_WB_Flush,
                       bus.exc_redirect, bus.muldiv_done};
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %b expected %b at %0t",
                             e.name, act, e.exp, $time);
                end
`ifdef PIPE_STALL_CNT_EN
                if (!rst_n) m_stalls = 32'd0;
                total++;
                if (stall_cycles !== m_stalls) begin
                    bad++;
                    $display("FAIL stall_cycles(%s): got %0d expected %0d",
                             e.name, stall_cycles, m_stalls);
                end
                if (rst_n && e.exp[10] && m_stalls != 32'hFFFF_FFFF)
                    m_stalls = m_stalls + 32'd1;
`endif
            end
        end
    end

    // Directed stimulus
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.load_use_hazard = 1'b0;
        bus.muldiv_start    = 1'b0;
        bus.dmem_req        = 1'b0;
        bus.dmem_data_ok    = 1'b0;
        bus.exc_valid       = 1'b0;

        // Outputs held low during reset even with an exception asserted
        step(1'b0, c_IEXC, c_Z, "rst_out0");
        step(1'b0, 5'b11101, c_Z, "rst_out1");
        step(1'b1, c_I0, c_Z, "idle");

        // mul/div: 4 stall cycles then done; other inputs ignored in MULDIV
        step(1'b1, c_IMD, c_MD, "md_c1");
        step(1'b1, 5'b11100, c_MD, "md_c2");
        step(1'b1, 5'b11100, c_MD, "md_c3");
        step(1'b1, 5'b11100, c_MD, "md_c4");
        step(1'b1, c_IMD, c_DONE, "md_done");
        step(1'b1, c_I0, c_Z, "md_after");

        // memory wait for 3 cycles, then data_ok; MEM_WAIT ignores others
        step(1'b1, c_IMEM, c_MEMW, "mem_w1");
        step(1'b1, 5'b11101, c_MEMW, "mem_w2");
        step(1'b1, 5'b11101, c_MEMW, "mem_w3");
        step(1'b1, 5'b11111, c_Z, "mem_ok");
        step(1'b1, c_ILU, c_LU, "lu_after_mem");

        // completed access in RUN falls through to lower priorities
        step(1'b1, 5'b10110, c_LU, "mem_ok_lu");
        step(1'b1, c_I0, c_Z, "idle2");

        // exception during the second mul/div stall cycle
        step(1'b1, c_IMD, c_MD, "mdx_c1");
        step(1'b1, c_IEXC, c_EXC, "mdx_exc");
        step(1'b1, c_I0, c_Z, "mdx_nodone");
        step(1'b1, c_ILU, c_LU, "mdx_run");

        // all hazards at once: memory wins, then mul/div after data_ok
        step(1'b1, 5'b11100, c_MEMW, "prio_mem");
        step(1'b1, 5'b01010, c_Z, "prio_ok");
        step(1'b1, 5'b01110, c_MD, "prio_md1");
        step(1'b1, c_I0, c_MD, "prio_md2");
        step(1'b1, c_I0, c_MD, "prio_md3");
        step(1'b1, c_I0, c_MD, "prio_md4");
        step(1'b1, c_I0, c_DONE, "prio_done");

        // exception beats everything in RUN
        step(1'b1, 5'b11101, c_EXC, "prio_exc");
        step(1'b1, c_I0, c_Z, "exc_after");

        // asynchronous reset in the middle of a mul/div stall
        step(1'b1, c_IMD, c_MD, "rmd_c1");
        step(1'b1, c_I0, c_MD, "rmd_c2");
        step(1'b0, c_I0, c_Z, "rmd_rst0");
        step(1'b0, c_I0, c_Z, "rmd_rst1");
        step(1'b1, c_I0, c_Z, "rmd_rel0");
        step(1'b1, c_I0, c_Z, "rmd_rel1");
        step(1'b1, c_ILU, c_LU, "rmd_run");
        step(1'b1, c_I0, c_Z, "final_idle");

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
